game_round_ctrl: RTL and testbench

Round sequencer for the teeter game. It starts a game, gates hole detection through `o_playing`, and latches the position of whichever hole the ball fell into. It then runs the fall animation and the result hold, and updates level and lives. It sits between the hole-detection block (`o_win`/`o_fail`/fall position feed this block; `o_playing` feeds its `is_game_playing`) and the renderer/level loader.

---
 rtl/game_round_ctrl.sv | 169 ++++++++++++++++
 tb/tb_game_round_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_ctrl.sv
// Round sequencer for the teeter game: start, ball-in-hole capture, fall
// animation, result hold, and level/lives bookkeeping up to game over.
module game_round_ctrl #(
    parameter int FALL_FRAMES = 16,
    parameter int SHOW_FRAMES = 60,
    parameter int NUM_LEVELS  = 4,
    parameter int INIT_LIVES  = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_frame_tick,
    input  logic       i_win,
    input  logic       i_fail,
    input  logic [9:0] i_pos_fall_x,
    input  logic [9:0] i_pos_fall_y,
    output logic       o_playing,
    output logic [2:0] o_state,
    output logic [3:0] o_level,
    output logic [2:0] o_lives,
    output logic [9:0] o_fall_x,
    output logic [9:0] o_fall_y,
    output logic [7:0] o_fall_frame,
    output logic       o_result_win,
    output logic       o_level_load,
    output logic       o_cleared
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLAYING = 3'd1,
        S_FALLING = 3'd2,
        S_RESULT  = 3'd3,
        S_OVER    = 3'd4
    } state_e;

    localparam logic [7:0] FALL_LAST  = 8'(FALL_FRAMES - 1);
    localparam logic [7:0] SHOW_LAST  = 8'(SHOW_FRAMES - 1);
    localparam logic [3:0] LAST_LEVEL = 4'(NUM_LEVELS - 1);
    localparam logic [2:0] START_LIVES = 3'(INIT_LIVES);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] level_q, level_d;
    logic [2:0] lives_q, lives_d;
    logic [9:0] fall_x_q, fall_x_d;
    logic [9:0] fall_y_q, fall_y_d;
    logic       result_win_q, result_win_d;
    logic       game_end_q, game_end_d;
    logic       load_q, load_d;
    logic       playing_q, playing_d;
    logic       cleared_q, cleared_d;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case leaves one unassigned (no latch).
        state_d      = state_q;
        cnt_d        = cnt_q;
        level_d      = level_q;
        lives_d      = lives_q;
        fall_x_d     = fall_x_q;
        fall_y_d     = fall_y_q;
        result_win_d = result_win_q;
        game_end_d   = game_end_q;
        cleared_d    = cleared_q;

        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (i_start) begin
                    state_d   = S_PLAYING;
                    level_d   = '0;
                    lives_d   = START_LIVES;
                    cleared_d = 1'b0;
                end
            end

            S_PLAYING: begin
                if (i_win || i_fail) begin
                    fall_x_d     = i_pos_fall_x;
                    fall_y_d     = i_pos_fall_y;
                    result_win_d = i_win;
                    cnt_d        = '0;
                    state_d      = S_FALLING;
                end
            end

            S_FALLING: begin
                if (i_frame_tick) begin
                    if (cnt_q == FALL_LAST) begin
                        cnt_d   = '0;
                        state_d = S_RESULT;
                        // The end-of-game decision needs the pre-update level/lives,
                        // which saturation would otherwise hide, so capture it here.
                        if (result_win_q) begin
                            game_end_d = (level_q == LAST_LEVEL);
                            if (level_q != LAST_LEVEL) level_d = level_q + 4'd1;
                        end else begin
                            game_end_d = (lives_q <= 3'd1);
                            if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            S_RESULT: begin
                if (i_frame_tick) begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d = '0;
                        if (game_end_q) begin
                            state_d   = S_OVER;
                            cleared_d = result_win_q;
                        end else begin
                            state_d = S_PLAYING;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        playing_d = (state_d == S_PLAYING);
        load_d    = (state_d == S_PLAYING) && (state_q != S_PLAYING);
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments only in clocked logic, so every flop samples pre-edge values.
        if (!i_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            level_q      <= '0;
            lives_q      <= START_LIVES;
            fall_x_q     <= '0;
            fall_y_q     <= '0;
            result_win_q <= 1'b0;
            game_end_q   <= 1'b0;
            load_q       <= 1'b0;
            playing_q    <= 1'b0;
            cleared_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            lives_q      <= lives_d;
            fall_x_q     <= fall_x_d;
            fall_y_q     <= fall_y_d;
            result_win_q <= result_win_d;
            game_end_q   <= game_end_d;
            load_q       <= load_d;
            playing_q    <= playing_d;
            cleared_q    <= cleared_d;
        end
    end

    assign o_playing    = playing_q;
    assign o_state      = state_q;
    assign o_level      = level_q;
    assign o_lives      = lives_q;
    assign o_fall_x     = fall_x_q;
    assign o_fall_y     = fall_y_q;
    assign o_fall_frame = cnt_q;
    assign o_result_win = result_win_q;
    assign o_level_load = load_q;
    assign o_cleared    = cleared_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: directed round scenarios followed by
// random play, every cycle compared against a tick-countdown game model.
module tb_game_round_ctrl;

    localparam int FALL = 4;
    localparam int SHOW = 2;
    localparam int NLEV = 2;
    localparam int ILIV = 2;

    localparam int ST_IDLE    = 0;
    localparam int ST_PLAYING = 1;
    localparam int ST_FALLING = 2;
    localparam int ST_RESULT  = 3;
    localparam int ST_OVER    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       tick;
    logic       win;
    logic       fail;
    logic [9:0] px;
    logic [9:0] py;

    logic       o_playing;
    logic [2:0] o_state;
    logic [3:0] o_level;
    logic [2:0] o_lives;
    logic [9:0] o_fall_x;
    logic [9:0] o_fall_y;
    logic [7:0] o_fall_frame;
    logic       o_result_win;
    logic       o_level_load;
    logic       o_cleared;

    always #5 clk = ~clk;

    game_round_ctrl #(
        .FALL_FRAMES(FALL),
        .SHOW_FRAMES(SHOW),
        .NUM_LEVELS (NLEV),
        .INIT_LIVES (ILIV)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_frame_tick (tick),
        .i_win        (win),
        .i_fail       (fail),
        .i_pos_fall_x (px),
        .i_pos_fall_y (py),
        .o_playing    (o_playing),
        .o_state      (o_state),
        .o_level      (o_level),
        .o_lives      (o_lives),
        .o_fall_x     (o_fall_x),
        .o_fall_y     (o_fall_y),
        .o_fall_frame (o_fall_frame),
        .o_result_win (o_result_win),
        .o_level_load (o_level_load),
        .o_cleared    (o_cleared)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Game model: tracks how many ticks remain in the current animation phase.
    int m_state, m_level, m_lives, m_fx, m_fy, m_ticks_left;
    bit m_win, m_load, m_cleared, m_game_end;

    task automatic model_step();
        m_load = 1'b0;
        if (!rst) begin
            m_state = ST_IDLE; m_level = 0; m_lives = ILIV;
            m_fx = 0; m_fy = 0; m_win = 1'b0; m_cleared = 1'b0;
            m_ticks_left = 0; m_game_end = 1'b0;
            return;
        end
        case (m_state)
            ST_IDLE, ST_OVER: if (start) begin
                m_state = ST_PLAYING; m_level = 0; m_lives = ILIV;
                m_cleared = 1'b0; m_load = 1'b1;
            end
            ST_PLAYING: if (win || fail) begin
                m_fx = px; m_fy = py; m_win = win;
                m_state = ST_FALLING; m_ticks_left = FALL;
            end
            ST_FALLING: if (tick) begin
                m_ticks_left--;
                if (m_ticks_left == 0) begin
                    m_game_end = m_win ? (m_level == NLEV - 1) : (m_lives == 1);
                    if (m_win) m_level = (m_level + 1 > NLEV - 1) ? NLEV - 1 : m_level + 1;
                    else       m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                    m_state = ST_RESULT; m_ticks_left = SHOW;
                end
            end
            ST_RESULT: if (tick) begin
                m_ticks_left--;
                if (m_ticks_left == 0) begin
                    if (m_game_end) begin
                        m_state = ST_OVER; m_cleared = m_win;
                    end else begin
                        m_state = ST_PLAYING; m_load = 1'b1;
                    end
                end
            end
            default: m_state = ST_IDLE;
        endcase
    endtask

    task automatic compare_all();
        check("state",      32'(o_state),      32'(m_state));
        check("playing",    32'(o_playing),    32'(m_state == ST_PLAYING));
        check("level",      32'(o_level),      32'(m_level));
        check("lives",      32'(o_lives),      32'(m_lives));
        check("fall_x",     32'(o_fall_x),     32'(m_fx));
        check("fall_y",     32'(o_fall_y),     32'(m_fy));
        check("result_win", 32'(o_result_win), 32'(m_win));
        check("level_load", 32'(o_level_load), 32'(m_load));
        check("cleared",    32'(o_cleared),    32'(m_cleared));
        if (m_state == ST_FALLING)
            check("fall_frame", 32'(o_fall_frame), 32'(FALL - m_ticks_left));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1; cycle();
            tick = 1'b0; cycle();
        end
    endtask

    task automatic do_start();
        start = 1'b1; cycle();
        start = 1'b0; cycle();
    endtask

    task automatic hole(input bit w, input bit f, input int x, input int y);
        win = w; fail = f; px = 10'(x); py = 10'(y);
        cycle();
        win = 1'b0; fail = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; tick = 1'b0; win = 1'b0; fail = 1'b0;
        px = '0; py = '0;

        // Reset and start
        cycle(); cycle();
        check("rst_state", 32'(o_state), 32'd0);
        check("rst_lives", 32'(o_lives), 32'd2);
        rst = 1'b1; cycle();
        start = 1'b1; cycle();
        check("start_state", 32'(o_state), 32'd1);
        check("start_load",  32'(o_level_load), 32'd1);
        start = 1'b0; cycle();
        check("start_load_drop", 32'(o_level_load), 32'd0);

        // Fail path, with start held high to confirm it is ignored
        start = 1'b1;
        hole(1'b0, 1'b1, 100, 200);
        check("fail_fx",    32'(o_fall_x), 32'd100);
        check("fail_fy",    32'(o_fall_y), 32'd200);
        check("fail_state", 32'(o_state),  32'd2);
        for (int i = 0; i < FALL; i++) begin
            check("fail_frame", 32'(o_fall_frame), 32'(i));
            tick = 1'b1; cycle();
            tick = 1'b0; cycle();
        end
        start = 1'b0;
        check("fail_result", 32'(o_state), 32'd3);
        check("fail_lives",  32'(o_lives), 32'd1);
        ticks(1);
        tick = 1'b1; cycle(); tick = 1'b0;
        check("fail_replay", 32'(o_state), 32'd1);
        check("fail_load",   32'(o_level_load), 32'd1);
        check("fail_level",  32'(o_level), 32'd0);
        cycle();

        // Simultaneous win and fail: win takes priority
        hole(1'b1, 1'b1, 320, 240);
        check("both_win", 32'(o_result_win), 32'd1);
        check("both_fx",  32'(o_fall_x), 32'd320);
        ticks(FALL);
        check("both_level", 32'(o_level), 32'd1);
        ticks(SHOW);
        check("both_replay", 32'(o_state), 32'd1);

        // Game over by losing both lives
        rst = 1'b0; cycle(); rst = 1'b1; cycle();
        do_start();
        hole(1'b0, 1'b1, 5, 6); ticks(FALL + SHOW);
        hole(1'b0, 1'b1, 7, 8); ticks(FALL + SHOW);
        check("over_state",   32'(o_state),   32'd4);
        check("over_cleared", 32'(o_cleared), 32'd0);
        check("over_lives",   32'(o_lives),   32'd0);
        do_start();
        check("restart_lives", 32'(o_lives), 32'd2);
        check("restart_level", 32'(o_level), 32'd0);

        // Clear by winning both levels, then win pulses in OVER do nothing
        hole(1'b1, 1'b0, 11, 12); ticks(FALL + SHOW);
        hole(1'b1, 1'b0, 13, 14); ticks(FALL + SHOW);
        check("clear_state",   32'(o_state),   32'd4);
        check("clear_cleared", 32'(o_cleared), 32'd1);
        check("clear_level",   32'(o_level),   32'd1);
        hole(1'b1, 1'b0, 500, 501); cycle();
        check("over_win_ignored", 32'(o_fall_x), 32'd13);

        // Reset in the middle of the fall, together with a tick
        do_start();
        hole(1'b0, 1'b1, 99, 98);
        ticks(2);
        check("midrst_frame", 32'(o_fall_frame), 32'd2);
        rst = 1'b0; tick = 1'b1; cycle();
        check("midrst_state",  32'(o_state),  32'd0);
        check("midrst_lives",  32'(o_lives),  32'd2);
        check("midrst_fall_x", 32'(o_fall_x), 32'd0);
        rst = 1'b1; tick = 1'b0; cycle();

        // Random play
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(299) != 0);
            start = ($urandom_range(7) == 0);
            tick  = ($urandom_range(1) == 0);
            win   = ($urandom_range(11) == 0);
            fail  = ($urandom_range(9) == 0);
            px    = 10'($urandom);
            py    = 10'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
